// File: rtl/qspi_psram_responder.sv
// QSPI PSRAM device model: decodes EBh quad reads and 38h quad writes into a byte memory,
// with a backdoor port; all link inputs are oversampled in clk (3 clk from SCK edge to action).
module qspi_psram_responder #(
  parameter int ADDR_WIDTH  = 24,
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         psram_sck,
  input  logic                         psram_ce_n,
  input  logic [3:0]                   psram_d_i,
  output logic [3:0]                   psram_d_o,
  output logic [3:0]                   psram_douten,
  output logic                         busy,
  output logic                         cmd_err,
  input  logic                         bd_we,
  input  logic [$clog2(MEM_BYTES)-1:0] bd_addr,
  input  logic [7:0]                   bd_wdata,
  output logic [7:0]                   bd_rdata
);

  localparam int PW = $clog2(MEM_BYTES);
  localparam logic [7:0] ADDR_LAST = 8'(ADDR_WIDTH / 4 - 1);
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WAIT, S_RDATA, S_WDATA, S_IGNORE
  } state_t;

  logic [1:0]    sck_sync_q, ce_sync_q;
  logic [3:0]    d_s1_q, d_s2_q;
  logic          sck_prev_q, ce_prev_q;
  logic          sck_rise, sck_fall, ce_rise, ce_fall;

  state_t        state_q;
  logic [7:0]    cnt_q;
  logic [6:0]    cmd_q;
  logic [7:0]    cmd_d;
  logic [PW-1:0] ptr_q;
  logic          rd_q, phase_q, wait_done_q;
  logic [3:0]    nib_hi_q, dout_q, douten_q;
  logic          busy_q, cmd_err_q;
  logic          wr_vld_q;
  logic [PW-1:0] wr_addr_q;
  logic [7:0]    wr_dat_q;
  logic [7:0]    bd_rdata_q;
  logic [7:0]    rd_byte;
  logic [7:0]    mem [MEM_BYTES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q <= 2'b00;
      ce_sync_q  <= 2'b11;
      d_s1_q     <= 4'h0;
      d_s2_q     <= 4'h0;
      sck_prev_q <= 1'b0;
      ce_prev_q  <= 1'b1;
    end else begin
      sck_sync_q <= {sck_sync_q[0], psram_sck};
      ce_sync_q  <= {ce_sync_q[0], psram_ce_n};
      d_s1_q     <= psram_d_i;
      d_s2_q     <= d_s1_q;
      sck_prev_q <= sck_sync_q[1];
      ce_prev_q  <= ce_sync_q[1];
    end
  end

  assign sck_rise = sck_sync_q[1] & ~sck_prev_q;
  assign sck_fall = ~sck_sync_q[1] & sck_prev_q;
  assign ce_rise  = ce_sync_q[1] & ~ce_prev_q;
  assign ce_fall  = ~ce_sync_q[1] & ce_prev_q;
  assign cmd_d    = {cmd_q, d_s2_q[0]};
  assign rd_byte  = mem[ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      cmd_q       <= 7'd0;
      ptr_q       <= '0;
      rd_q        <= 1'b0;
      phase_q     <= 1'b0;
      wait_done_q <= 1'b0;
      nib_hi_q    <= 4'h0;
      dout_q      <= 4'h0;
      douten_q    <= 4'h0;
      busy_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      wr_vld_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_dat_q    <= 8'h00;
    end else begin
      cmd_err_q <= 1'b0;
      wr_vld_q  <= 1'b0;
      if (ce_rise) begin
        // a half-received write byte is simply dropped here
        state_q  <= S_IDLE;
        douten_q <= 4'h0;
        dout_q   <= 4'h0;
        busy_q   <= 1'b0;
        phase_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (ce_fall) begin
            state_q <= S_CMD;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b1;
          end
          S_CMD: if (sck_rise) begin
            cmd_q <= cmd_d[6:0];
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == 8'd7) begin
              cnt_q <= 8'd0;
              if (cmd_d == 8'hEB) begin
                state_q <= S_ADDR;
                rd_q    <= 1'b1;
              end else if (cmd_d == 8'h38) begin
                state_q <= S_ADDR;
                rd_q    <= 1'b0;
              end else begin
                state_q   <= S_IGNORE;
                cmd_err_q <= 1'b1;
                busy_q    <= 1'b0;
              end
            end
          end
          // shifting straight into the pointer drops the address bits above PW
          S_ADDR: if (sck_rise) begin
            ptr_q <= {ptr_q[PW-5:0], d_s2_q};
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == ADDR_LAST) begin
              cnt_q       <= 8'd0;
              phase_q     <= 1'b0;
              wait_done_q <= 1'b0;
              state_q     <= rd_q ? S_WAIT : S_WDATA;
            end
          end
          S_WAIT: begin
            if (sck_rise) begin
              cnt_q <= cnt_q + 8'd1;
              if (cnt_q == WAIT_LAST) wait_done_q <= 1'b1;
            end
            if (sck_fall && wait_done_q) begin
              state_q  <= S_RDATA;
              douten_q <= 4'hF;
              dout_q   <= rd_byte[7:4];
              phase_q  <= 1'b1;
            end
          end
          S_RDATA: if (sck_fall) begin
            if (phase_q) begin
              dout_q  <= rd_byte[3:0];
              ptr_q   <= ptr_q + PW'(1);
              phase_q <= 1'b0;
            end else begin
              dout_q  <= rd_byte[7:4];
              phase_q <= 1'b1;
            end
          end
          S_WDATA: if (sck_rise) begin
            if (!phase_q) begin
              nib_hi_q <= d_s2_q;
              phase_q  <= 1'b1;
            end else begin
              wr_vld_q  <= 1'b1;
              wr_addr_q <= ptr_q;
              wr_dat_q  <= {nib_hi_q, d_s2_q};
              ptr_q     <= ptr_q + PW'(1);
              phase_q   <= 1'b0;
            end
          end
          S_IGNORE: ;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // protocol write is issued last so it wins an address collision with the backdoor
  always_ff @(posedge clk) begin
    if (bd_we)    mem[bd_addr]   <= bd_wdata;
    if (wr_vld_q) mem[wr_addr_q] <= wr_dat_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bd_rdata_q <= 8'h00;
    else     bd_rdata_q <= mem[bd_addr];
  end

  assign psram_d_o    = dout_q;
  assign psram_douten = douten_q;
  assign busy         = busy_q;
  assign cmd_err      = cmd_err_q;
  assign bd_rdata     = bd_rdata_q;

endmodule

// File: tb/tb_qspi_psram_responder.sv
// Directed bench for qspi_psram_responder: acts as the PSRAM controller (SCK half period = 5 clk).
module tb_qspi_psram_responder;

  localparam int H = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       psram_sck, psram_ce_n;
  logic [3:0] psram_d_i, psram_d_o, psram_douten;
  logic       busy, cmd_err, bd_we;
  logic [9:0] bd_addr;
  logic [7:0] bd_wdata, bd_rdata;

  int n_checks = 0;
  int n_pass = 0;
  int quiet_err = 0;
  int busy_err = 0;
  int err_pulses = 0;
  logic quiet_chk = 1'b0;
  logic busy_chk = 1'b0;

  qspi_psram_responder dut (
    .clk(clk), .rst(rst), .psram_sck(psram_sck), .psram_ce_n(psram_ce_n),
    .psram_d_i(psram_d_i), .psram_d_o(psram_d_o), .psram_douten(psram_douten),
    .busy(busy), .cmd_err(cmd_err), .bd_we(bd_we), .bd_addr(bd_addr),
    .bd_wdata(bd_wdata), .bd_rdata(bd_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (quiet_chk && psram_douten != 4'h0) quiet_err++;
    if (busy_chk && !busy) busy_err++;
    if (cmd_err) err_pulses++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_nib(input logic [3:0] n);
    psram_d_i = n;
    tick(H);
    psram_sck = 1'b1;
    tick(H);
    psram_sck = 1'b0;
  endtask

  task automatic read_nib(output logic [3:0] n, output logic [3:0] oe);
    tick(H);
    n  = psram_d_o;
    oe = psram_douten;
    psram_sck = 1'b1;
    tick(H);
    psram_sck = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) send_nib({3'b000, c[i]});
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) send_nib(a[4*i +: 4]);
  endtask

  task automatic start_txn(input logic [7:0] c, input logic [23:0] a);
    psram_ce_n = 1'b0;
    tick(H);
    busy_chk  = 1'b1;
    quiet_chk = 1'b1;
    send_cmd(c);
    send_addr(a);
  endtask

  task automatic rd_begin(input logic [23:0] a);
    start_txn(8'hEB, a);
    for (int i = 0; i < 8; i++) send_nib(4'h0);
    quiet_chk = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    send_nib(b[7:4]);
    send_nib(b[3:0]);
  endtask

  task automatic read_byte(output logic [7:0] b, output logic oe_ok);
    logic [3:0] hi, lo, oe_h, oe_l;
    read_nib(hi, oe_h);
    read_nib(lo, oe_l);
    b = {hi, lo};
    oe_ok = (oe_h == 4'hF) && (oe_l == 4'hF);
  endtask

  task automatic stop_txn();
    busy_chk  = 1'b0;
    quiet_chk = 1'b0;
    tick(H);
    psram_ce_n = 1'b1;
    tick(3 * H);
  endtask

  task automatic bd_write(input logic [9:0] a, input logic [7:0] d);
    bd_addr = a; bd_wdata = d; bd_we = 1'b1;
    tick(1);
    bd_we = 1'b0;
  endtask

  task automatic bd_read(input logic [9:0] a, output logic [7:0] d);
    bd_addr = a;
    tick(1);
    d = bd_rdata;
  endtask

  typedef struct {
    logic        is_wr;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic [9:0]  chk_addr;
    logic [7:0]  exp;
  } vec_t;

  vec_t vt [6];
  logic [3:0] exp_n [8];
  logic [3:0] nib, oe;
  logic [7:0] b;
  logic       oe_ok;

  initial begin
    vt[0] = '{1'b1, 24'h000040, 8'h3C, 10'h040, 8'h3C};
    vt[1] = '{1'b0, 24'h000040, 8'h00, 10'h040, 8'h3C};
    vt[2] = '{1'b1, 24'hABC050, 8'h96, 10'h050, 8'h96};
    vt[3] = '{1'b0, 24'h000050, 8'h00, 10'h050, 8'h96};
    vt[4] = '{1'b1, 24'h0003FE, 8'hE1, 10'h3FE, 8'hE1};
    vt[5] = '{1'b0, 24'h1003FE, 8'h00, 10'h3FE, 8'hE1};
    exp_n = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4};

    rst = 1'b1; psram_sck = 1'b0; psram_ce_n = 1'b1; psram_d_i = 4'h0;
    bd_we = 1'b0; bd_addr = 10'h0; bd_wdata = 8'h00;
    tick(3);
    check("reset d_o", 32'(psram_d_o), 32'h0);
    check("reset douten", 32'(psram_douten), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset cmd_err", 32'(cmd_err), 32'h0);
    check("reset bd_rdata", 32'(bd_rdata), 32'h0);
    rst = 1'b0;
    tick(2);

    bd_write(10'h010, 8'h11); bd_write(10'h011, 8'h22);
    bd_write(10'h012, 8'h33); bd_write(10'h013, 8'h44);
    bd_write(10'h3FF, 8'hC3); bd_write(10'h000, 8'h7E);

    // 4-byte burst read
    rd_begin(24'h000010);
    for (int i = 0; i < 8; i++) begin
      busy_chk = 1'b1;
      read_nib(nib, oe);
      check($sformatf("burst nib%0d", i), 32'(nib), 32'(exp_n[i]));
      check($sformatf("burst oe%0d", i), 32'(oe), 32'hF);
    end
    stop_txn();

    // two-byte write
    start_txn(8'h38, 24'h000020);
    write_byte(8'hA5);
    write_byte(8'h5A);
    stop_txn();
    check("busy after write", 32'(busy), 32'h0);
    bd_read(10'h020, b); check("write 0x20", 32'(b), 32'hA5);
    bd_read(10'h021, b); check("write 0x21", 32'(b), 32'h5A);

    for (int i = 0; i < 6; i++) begin
      if (vt[i].is_wr) begin
        start_txn(8'h38, vt[i].addr);
        write_byte(vt[i].wdata);
        stop_txn();
        bd_read(vt[i].chk_addr, b);
        check($sformatf("vec%0d wr", i), 32'(b), 32'(vt[i].exp));
      end else begin
        rd_begin(vt[i].addr);
        read_byte(b, oe_ok);
        stop_txn();
        check($sformatf("vec%0d rd", i), 32'(b), 32'(vt[i].exp));
        check($sformatf("vec%0d oe", i), 32'(oe_ok), 32'h1);
      end
    end

    // pointer wrap and high-address aliasing
    rd_begin(24'h0003FF);
    read_byte(b, oe_ok); check("wrap byte0", 32'(b), 32'hC3);
    read_byte(b, oe_ok); check("wrap byte1", 32'(b), 32'h7E);
    stop_txn();
    rd_begin(24'hFFFC00);
    read_byte(b, oe_ok); check("alias 0xFFFC00", 32'(b), 32'h7E);
    stop_txn();

    // unsupported command
    check("no cmd_err yet", 32'(err_pulses), 32'h0);
    psram_ce_n = 1'b0;
    tick(H);
    quiet_chk = 1'b1;
    send_cmd(8'h9F);
    tick(2);
    check("busy in ignore", 32'(busy), 32'h0);
    send_addr(24'h000010);
    for (int i = 0; i < 4; i++) send_nib(4'h0);
    stop_txn();
    check("cmd_err pulses", 32'(err_pulses), 32'h1);
    rd_begin(24'h000011);
    read_byte(b, oe_ok); check("read after 9F", 32'(b), 32'h22);
    stop_txn();

    // write aborted after one nibble
    start_txn(8'h38, 24'h000012);
    send_nib(4'hF);
    stop_txn();
    check("busy after abort", 32'(busy), 32'h0);
    bd_read(10'h012, b); check("partial write", 32'(b), 32'h33);
    rd_begin(24'h000012);
    read_byte(b, oe_ok); check("read after abort", 32'(b), 32'h33);
    stop_txn();

    // reset in the middle of read data
    rd_begin(24'h000010);
    read_nib(nib, oe);
    check("pre-reset nib", 32'(nib), 32'h1);
    tick(H);
    check("pre-reset oe", 32'(psram_douten), 32'hF);
    busy_chk = 1'b0;
    rst = 1'b1;
    #2;
    check("rst douten", 32'(psram_douten), 32'h0);
    check("rst d_o", 32'(psram_d_o), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    psram_ce_n = 1'b1; psram_sck = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(H);
    rd_begin(24'h000010);
    read_byte(b, oe_ok); check("post-rst byte0", 32'(b), 32'h11);
    read_byte(b, oe_ok); check("post-rst byte1", 32'(b), 32'h22);
    stop_txn();
    bd_read(10'h021, b); check("mem kept 0x21", 32'(b), 32'h5A);

    check("douten quiet outside data", 32'(quiet_err), 32'h0);
    check("busy held in txn", 32'(busy_err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/qspi_psram_responder.md
# qspi_psram_responder

Synthesizable QSPI PSRAM responder: the device end of the `psram_sck`/`psram_ce_n`/`psram_d` link driven by the team's PSRAM controller. It decodes quad-read (EBh) and quad-write (38h) transactions into a small on-chip byte memory. It stands in for external PSRAM in on-chip self-test and in simulation of the conv/weight-loading layers. A backdoor port preloads weights and biases and inspects stored results.

## Interface
Parameters:
- `ADDR_WIDTH`, 24: address bits received per transaction.
- `MEM_BYTES`, 1024: backing memory size in bytes (power of two).
- `WAIT_CYCLES`, 8: dummy SCK cycles between address and read data.

Ports:
- `clk`, in, 1: system clock; sole clock. One clock; reset is asynchronous and active-high.
- `rst`, in, 1: asynchronous active-high reset.
- `psram_sck`, in, 1: serial clock from the controller, oversampled in `clk`.
- `psram_ce_n`, in, 1: active-low chip enable.
- `psram_d_i`, in, 4: data lines into the responder.
- `psram_d_o`, out, 4: data lines driven by the responder.
- `psram_douten`, out, 4: per-line output enable, 1 = responder drives.
- `busy`, out, 1: high while a transaction is decoded (CE low and not IGNORE).
- `cmd_err`, out, 1: one-`clk` pulse when an unsupported command byte is received.
- `bd_we`, in, 1: backdoor write strobe.
- `bd_addr`, in, log2(`MEM_BYTES`): backdoor byte address.
- `bd_wdata`, in, 8: backdoor write data.
- `bd_rdata`, out, 8: registered backdoor read data (1-cycle latency).

## Operation
- Input synchronisation: `psram_sck`, `psram_ce_n`, `psram_d_i` pass through 2-FF synchronisers. Rising and falling SCK edges are detected on the synchronised SCK.
- Rising SCK edge: the responder samples inputs. Falling SCK edge: the responder updates outputs.
- A synchronised CE rising edge in any state forces IDLE. It clears `psram_douten` and `psram_d_o` and discards any partial write byte.
- FSM states: IDLE, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE.
- IDLE → CMD on CE falling edge. Bit counter cleared.
- CMD: 8 rising edges, `d_i[0]` only, MSB first.
  - EBh → ADDR (read).
  - 38h → ADDR (write).
  - Anything else → IGNORE, with `cmd_err` pulsed.
- ADDR: `ADDR_WIDTH`/4 rising edges, 4 bits per edge, MSB nibble first. The byte pointer is the address modulo `MEM_BYTES`; upper bits are ignored.
- WAIT (read only): counts `WAIT_CYCLES` rising edges. On the falling edge after the last one, go to RDATA and drive the first nibble.
- Write path: ADDR → WDATA directly.
- RDATA:
  - `psram_douten` = 4'hF.
  - Each falling edge presents the next nibble, high nibble of `mem[ptr]` first, then low nibble.
  - After the low nibble, `ptr` increments; the next byte is fetched in time for the next falling edge.
  - Continues until CE high.
- WDATA:
  - Each rising edge captures a nibble, high first.
  - The second nibble commits `mem[ptr]` within 1 `clk` and increments `ptr`.
  - Continues until CE high.
- Pointer wrap: after `MEM_BYTES`-1, `ptr` wraps to 0 for both reads and writes.
- IGNORE: outputs off; waits for CE high.
- Backdoor:
  - Write and read operate at any time.
  - A protocol write and `bd_we` to the same address in the same cycle: the protocol write wins.
  - `bd_rdata` reflects memory contents after writes in the previous cycle.
- Memory contents are not reset.

## Timing
- Reset values: `psram_d_o`=0, `psram_douten`=0, `busy`=0, `cmd_err`=0, `bd_rdata`=0; FSM in IDLE; counters 0.
- `rst` takes effect immediately. An assertion mid-transaction aborts it; the controller's next CE low starts a fresh decode.
- SCK high and low phases must each be at least 4 `clk` periods. Faster SCK is unsupported.
- Edge-to-action latency: 3 `clk` from a physical SCK edge to the sample or output update. Read nibbles therefore settle at least 1 `clk` before the controller's next rising edge.
- Read latency: first data nibble valid after 8 + `ADDR_WIDTH`/4 + `WAIT_CYCLES` SCK cycles (22 with defaults).
- `cmd_err` asserts 1 `clk` after the 8th command bit is sampled.
- `busy` rises 1 `clk` after the synchronised CE falls. It falls 1 `clk` after the synchronised CE rises, or on entry to IGNORE.

## Test plan
- Backdoor-load `mem[0x10..0x13]` = 11,22,33,44; EBh read at 0x000010 for 4 bytes → nibbles 1,1,2,2,3,3,4,4; `douten`=F only during data; `busy` high for the whole transaction.
- 38h write of A5,5A at 0x000020, then CE high → backdoor read gives 0x20=A5 and 0x21=5A; `douten` stays 0 throughout.
- EBh read at 0x0003FF for 2 bytes (`MEM_BYTES`=1024) → returns `mem[0x3FF]` then `mem[0x000]`. Also address 0xFFFC00 aliases to 0x000.
- Command 9Fh → `cmd_err` single pulse; `douten` stays 0; `busy` low; the following EBh transaction decodes correctly.
- CE high after one nibble of a 38h write → target byte unchanged; FSM in IDLE.
- `rst` asserted mid-RDATA → `douten`=0 and `d_o`=0 immediately; a fresh EBh read returns correct data; memory contents intact.
